// File: rtl/mux_nto1_stream_if.sv
// Stream bundle for the N:1 multiplexer: CHANNELS producer lanes in, one consumer lane out.
interface mux_nto1_stream_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic                      out_ready;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
endinterface

// File: rtl/mux_nto1_stream.sv
// N:1 valid/ready multiplexer with a one-deep registered output.
// STATIC mode holds a commanded channel; SCAN mode round-robins with DWELL beats per channel.
module mux_nto1_stream #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int DWELL    = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic              clk,
   input  logic              rst_n,
   mux_nto1_stream_if.slave  bus,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel_in,
   input  logic              sel_load,
   output logic [SEL_W-1:0]  cur_sel,
   output logic              sel_err
);
   localparam int               CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(CHANNELS - 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DWELL - 1);

   typedef enum logic {ST_STATIC = 1'b0, ST_SCAN = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             err_nxt;
   logic [WIDTH-1:0] pick_data;
   logic             pick_valid, other_valid, sel_ok;
   logic             can_load, accept;
   logic [WIDTH-1:0] data_p1;
   logic             vld_p1;

   function automatic logic [SEL_W-1:0] next_chan(input logic [SEL_W-1:0] s);
      return (s == LAST_CH) ? '0 : s + SEL_W'(1);
   endfunction

   // Channel decode covers only k < CHANNELS, so unused select codes match nothing.
   always_comb begin
      pick_valid  = 1'b0;
      pick_data   = '0;
      other_valid = 1'b0;
      sel_ok      = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (cur_sel == SEL_W'(k)) begin
            pick_valid = bus.in_valid[k];
            pick_data  = bus.in_data[k*WIDTH +: WIDTH];
         end else if (bus.in_valid[k]) begin
            other_valid = 1'b1;
         end
         if (sel_in == SEL_W'(k)) sel_ok = 1'b1;
      end
   end

   assign can_load = !vld_p1 || bus.out_ready;
   assign accept   = pick_valid && can_load;

   always_comb begin
      bus.in_ready = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         bus.in_ready[k] = (cur_sel == SEL_W'(k)) && can_load;
      end
   end

   always_comb begin
      state_nxt = mode ? ST_SCAN : ST_STATIC;
      sel_nxt   = cur_sel;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;
      case (state)
         ST_STATIC: begin
            cnt_nxt = '0;
            if (sel_load) begin
               if (sel_ok) sel_nxt = sel_in;
               else        err_nxt = 1'b1;
            end
         end
         ST_SCAN: begin
            err_nxt = sel_load;
            if (accept) begin
               if (cnt == LAST_BEAT) begin
                  sel_nxt = next_chan(cur_sel);
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else if (!pick_valid && other_valid) begin
               // Idle skip: current lane is empty but someone else has data.
               sel_nxt = next_chan(cur_sel);
               cnt_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_STATIC;
         cur_sel <= '0;
         cnt     <= '0;
         sel_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         cur_sel <= sel_nxt;
         cnt     <= cnt_nxt;
         sel_err <= err_nxt;
      end
   end

   // Stage p1: output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         data_p1 <= pick_data;
      end else if (bus.out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.out_data  = data_p1;
   assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream: a 4-channel unit against a queue-based model, plus a
// 3-channel unit for out-of-range select handling.
module tb_mux_nto1_stream;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mode, sel_load;
   logic [1:0] sel_in, cur_sel;
   logic       sel_err;
   logic       mode3, sel_load3;
   logic [1:0] sel_in3, cur_sel3;
   logic       sel_err3;

   int n_vec = 0;
   int n_err = 0;

   mux_nto1_stream_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
   mux_nto1_stream_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

   mux_nto1_stream #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .mode(mode), .sel_in(sel_in),
      .sel_load(sel_load), .cur_sel(cur_sel), .sel_err(sel_err)
   );

   mux_nto1_stream #(.WIDTH(8), .CHANNELS(3), .DWELL(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .mode(mode3), .sel_in(sel_in3),
      .sel_load(sel_load3), .cur_sel(cur_sel3), .sel_err(sel_err3)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: output register as a queue of at most one byte, selection as an integer.
   logic [7:0] m_q[$];
   logic [7:0] got[$];
   int         m_sel  = 0;
   int         m_cnt  = 0;
   bit         m_scan = 1'b0;
   bit         m_err  = 1'b0;
   bit         m_take;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_sel = 0; m_cnt = 0; m_scan = 1'b0; m_err = 1'b0;
      end else begin
         m_take = bus4.in_valid[m_sel] && (m_q.size() == 0 || bus4.out_ready);
         if (m_q.size() > 0 && bus4.out_ready) void'(m_q.pop_front());
         if (m_take) m_q.push_back(bus4.in_data[m_sel*8 +: 8]);
         m_err = sel_load && m_scan;
         if (!m_scan) begin
            m_cnt = 0;
            if (sel_load) m_sel = sel_in;
         end else if (m_take) begin
            m_cnt++;
            if (m_cnt == 4) begin m_cnt = 0; m_sel = (m_sel + 1) % 4; end
         end else if (!bus4.in_valid[m_sel] && bus4.in_valid != 4'b0000) begin
            m_cnt = 0; m_sel = (m_sel + 1) % 4;
         end
         m_scan = mode;
      end
   end

   function automatic logic [3:0] exp_ready();
      logic [3:0] r = 4'b0000;
      if (m_q.size() == 0 || bus4.out_ready) r[m_sel] = 1'b1;
      return r;
   endfunction

   always @(negedge clk) begin
      check("out_valid", {31'd0, bus4.out_valid}, {31'd0, m_q.size() > 0});
      if (m_q.size() > 0) check("out_data", {24'd0, bus4.out_data}, {24'd0, m_q[0]});
      check("cur_sel", {30'd0, cur_sel}, m_sel);
      check("sel_err", {31'd0, sel_err}, {31'd0, m_err});
      check("in_ready", {28'd0, bus4.in_ready}, {28'd0, exp_ready()});
      if (bus4.out_valid && bus4.out_ready) got.push_back(bus4.out_data);
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic set_ch(input int k, input logic [7:0] v);
      bus4.in_data[k*8 +: 8] = v;
   endtask

   int scan_seq[16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};

   initial begin
      mode = 1'b0; sel_load = 1'b0; sel_in = 2'd0;
      bus4.in_data = '0; bus4.in_valid = '0; bus4.out_ready = 1'b1;
      mode3 = 1'b0; sel_load3 = 1'b0; sel_in3 = 2'd0;
      bus3.in_data = '0; bus3.in_valid = '0; bus3.out_ready = 1'b1;
      step(2);
      check("reset out_valid", {31'd0, bus4.out_valid}, 0);
      check("reset out_data", {24'd0, bus4.out_data}, 0);
      check("reset cur_sel", {30'd0, cur_sel}, 0);
      check("reset sel_err", {31'd0, sel_err}, 0);
      rst_n = 1'b1;
      step(1);

      // STATIC pass-through on ch2; the load cycle still completes a beat on ch0
      set_ch(0, 8'hA0); set_ch(1, 8'hB1); set_ch(3, 8'hD3);
      bus4.in_valid = 4'b1011; sel_in = 2'd2; sel_load = 1'b1;
      step(1);
      sel_load = 1'b0;
      check("load old channel beat", {24'd0, bus4.out_data}, 32'hA0);
      check("load cur_sel", {30'd0, cur_sel}, 2);
      set_ch(2, 8'h11); bus4.in_valid = 4'b1111;
      check("static in_ready", {28'd0, bus4.in_ready}, 32'b0100);
      step(1); check("pass 0x11", {24'd0, bus4.out_data}, 32'h11);
      set_ch(2, 8'h22);
      step(1); check("pass 0x22", {24'd0, bus4.out_data}, 32'h22);
      set_ch(2, 8'h33);
      step(1); check("pass 0x33", {24'd0, bus4.out_data}, 32'h33);
      bus4.in_valid = 4'b0000;
      step(1); check("drain out_valid", {31'd0, bus4.out_valid}, 0);

      // Backpressure on ch0
      sel_in = 2'd0; sel_load = 1'b1;
      step(1);
      sel_load = 1'b0;
      set_ch(0, 8'h41); bus4.in_valid = 4'b0001; bus4.out_ready = 1'b0;
      step(1); check("bp first beat", {24'd0, bus4.out_data}, 32'h41);
      set_ch(0, 8'h42);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("bp hold data", {24'd0, bus4.out_data}, 32'h41);
         check("bp in_ready0", {31'd0, bus4.in_ready[0]}, 0);
      end
      bus4.out_ready = 1'b1;
      step(1); check("bp release 0x42", {24'd0, bus4.out_data}, 32'h42);
      set_ch(0, 8'h43);
      step(1); check("bp next 0x43", {24'd0, bus4.out_data}, 32'h43);
      bus4.in_valid = 4'b0000;
      step(1);
      check("beats delivered", got.size(), 7);
      if (got.size() == 7) begin
         check("got[0]", {24'd0, got[0]}, 32'hA0);
         check("got[1]", {24'd0, got[1]}, 32'h11);
         check("got[2]", {24'd0, got[2]}, 32'h22);
         check("got[3]", {24'd0, got[3]}, 32'h33);
         check("got[4]", {24'd0, got[4]}, 32'h41);
         check("got[5]", {24'd0, got[5]}, 32'h42);
         check("got[6]", {24'd0, got[6]}, 32'h43);
      end
      got.delete();

      // Bad select on the 3-channel unit, then sel_load while scanning
      sel_in3 = 2'd2; sel_load3 = 1'b1;
      step(1);
      check("ch3 load cur_sel", {30'd0, cur_sel3}, 2);
      check("ch3 load no err", {31'd0, sel_err3}, 0);
      sel_in3 = 2'd3;
      step(1);
      sel_load3 = 1'b0;
      check("ch3 bad sel err", {31'd0, sel_err3}, 1);
      check("ch3 bad sel keeps", {30'd0, cur_sel3}, 2);
      step(1); check("ch3 err one cycle", {31'd0, sel_err3}, 0);
      mode3 = 1'b1;
      step(1);
      sel_in3 = 2'd0; sel_load3 = 1'b1;
      step(1);
      sel_load3 = 1'b0;
      check("ch3 scan load err", {31'd0, sel_err3}, 1);
      check("ch3 scan load keeps", {30'd0, cur_sel3}, 2);
      step(1); check("ch3 scan err clears", {31'd0, sel_err3}, 0);

      // SCAN dwell with all channels valid
      for (int k = 0; k < 4; k++) set_ch(k, 8'hC0 + 8'(k));
      mode = 1'b1;
      step(1);
      bus4.in_valid = 4'b1111;
      for (int i = 1; i <= 16; i++) begin
         step(1);
         check("scan cur_sel seq", {30'd0, cur_sel}, scan_seq[i-1]);
         if (i == 1)  check("scan data 1", {24'd0, bus4.out_data}, 32'hC0);
         if (i == 5)  check("scan data 5", {24'd0, bus4.out_data}, 32'hC1);
         if (i == 16) check("scan data 16", {24'd0, bus4.out_data}, 32'hC3);
      end
      bus4.in_valid = 4'b0000;
      step(1);
      sel_in = 2'd1; sel_load = 1'b1;
      step(1);
      sel_load = 1'b0;
      check("scan sel_load err", {31'd0, sel_err}, 1);
      check("scan sel_load ignored", {30'd0, cur_sel}, 0);
      step(1); check("scan err clears", {31'd0, sel_err}, 0);

      // Idle skip toward ch3, with backpressure once ch3 is reached
      bus4.in_valid = 4'b1000; bus4.out_ready = 1'b0;
      step(1); check("skip to 1", {30'd0, cur_sel}, 1);
      step(1); check("skip to 2", {30'd0, cur_sel}, 2);
      step(1); check("skip to 3", {30'd0, cur_sel}, 3);
      step(1); check("ch3 beat", {24'd0, bus4.out_data}, 32'hC3);
      step(2); check("bp no dwell advance", {30'd0, cur_sel}, 3);
      bus4.out_ready = 1'b1;
      step(1);
      mode = 1'b0;
      step(1); check("scan->static keeps", {30'd0, cur_sel}, 3);
      step(3); check("static holds ch3", {30'd0, cur_sel}, 3);
      check("ch3 flowing", {31'd0, bus4.out_valid}, 1);

      // Asynchronous reset mid-stream
      rst_n = 1'b0;
      #1;
      check("async out_valid", {31'd0, bus4.out_valid}, 0);
      check("async out_data", {24'd0, bus4.out_data}, 0);
      check("async cur_sel", {30'd0, cur_sel}, 0);
      step(2);
      rst_n = 1'b1;
      step(2);
      check("post reset idle", {31'd0, bus4.out_valid}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
